// File: rtl/hazard_stall_gen_pkg.sv
// Shared constants and the per-source hazard compare for hazard_stall_gen.
package hazard_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source stalls when a producer in E or M will not have its result ready
    // by the time D consumes it; $0 and unread sources never stall.
    function automatic logic src_hazard(
        input logic [4:0] s,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (s != REG_ZERO) && (tuse != TUSE_NONE) &&
               (((s == e_wa) && (e_tnew > tuse)) ||
                ((s == m_wa) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/hazard_stall_gen_if.sv
// Pipeline-side signal bundle for hazard_stall_gen; slave is the hazard unit.
interface hazard_stall_gen_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_md_use;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
        output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  stall, md_busy, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
        input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output stall, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_gen_md_busy_cnt.sv
// MULT/DIV busy tracker: loads the unit latency on issue and counts down to idle.
module md_busy_cnt #(
    parameter int MULT_LAT = hazard_pkg::MULT_LAT_DEF,
    parameter int DIV_LAT  = hazard_pkg::DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;

    assign state = (cnt != '0) ? BUSY : IDLE;

    // A start while BUSY is a protocol violation and deliberately does not reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) cnt <= div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                BUSY: cnt <= cnt - CNT_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    assign busy = start | (state == BUSY);
endmodule

// File: rtl/hazard_stall_gen.sv
// Pipeline stall request: Tuse/Tnew data hazards plus MULT/DIV busy interlock.
// Optional stall-cycle counter enabled with `define HZ_STALL_CNT_EN.
module hazard_stall_gen
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input logic           clk,
    input logic           reset,
    hazard_stall_gen_if.slave bus
);
    logic rs_hz, rt_hz, data_hazard, md_busy;

    assign rs_hz = src_hazard(bus.D_rs, bus.D_tuse_rs, bus.E_wa, bus.E_tnew, bus.M_wa, bus.M_tnew);
    assign rt_hz = src_hazard(bus.D_rt, bus.D_tuse_rt, bus.E_wa, bus.E_tnew, bus.M_wa, bus.M_tnew);
    assign data_hazard = rs_hz | rt_hz;

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md (
        .clk   (clk),
        .reset (reset),
        .start (bus.E_md_start),
        .div   (bus.E_md_div),
        .busy  (md_busy)
    );

    assign bus.md_busy = md_busy;
    assign bus.stall   = data_hazard | (bus.D_md_use & md_busy);

`ifdef HZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          stall_cnt_q <= '0;
        else if (bus.stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_gen.sv
// Directed bench for hazard_stall_gen; honours HZ_STALL_CNT_EN when defined.
`timescale 1ns/100ps
module tb_hazard_stall_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    hazard_stall_gen_if hz();

    hazard_stall_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    always #5 clk = ~clk;

`ifdef HZ_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        hz.D_rs = 5'd0; hz.D_rt = 5'd0;
        hz.D_tuse_rs = 2'd3; hz.D_tuse_rt = 2'd3;
        hz.D_md_use = 1'b0;
        hz.E_wa = 5'd0; hz.E_tnew = 2'd0;
        hz.M_wa = 5'd0; hz.M_tnew = 2'd0;
        hz.E_md_start = 1'b0; hz.E_md_div = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issuing MULT/DIV into a busy unit is illegal stimulus.
    always @(posedge clk) begin
        if (!reset && hz.E_md_start) begin
            tests++;
            assert (dut.u_md.cnt == '0) else begin
                fails++;
                $error("FAIL md_start_while_busy observed=%0h expected=0", dut.u_md.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        #1;
        chk("rst_md_busy", hz.md_busy, 0);
        chk("rst_stall", hz.stall, 0);
        chk("rst_stall_cnt", hz.stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Load-use on rs from E, then resolved once producer is in M
        hz.E_wa = 5'd8; hz.E_tnew = 2'd2; hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd1;
        #1 chk("loaduse_e", hz.stall, 1);
        tick();
        chk("loaduse_cnt", hz.stall_cnt, CNT_EN ? 32'd1 : 32'd0);
        hz.E_wa = 5'd0; hz.E_tnew = 2'd0; hz.M_wa = 5'd8; hz.M_tnew = 2'd1;
        #1 chk("loaduse_m_ok", hz.stall, 0);
        hz.D_tuse_rs = 2'd0;
        #1 chk("m_tnew1_tuse0", hz.stall, 1);
        idle_in();
        hz.D_rt = 5'd9; hz.D_tuse_rt = 2'd0; hz.E_wa = 5'd9; hz.E_tnew = 2'd1;
        #1 chk("rt_e_hazard", hz.stall, 1);
        hz.D_tuse_rt = 2'd1;
        #1 chk("rt_e_equal_ok", hz.stall, 0);
        idle_in();
        hz.D_rs = 5'd5; hz.D_tuse_rs = 2'd0;
        hz.E_wa = 5'd5; hz.E_tnew = 2'd0; hz.M_wa = 5'd5; hz.M_tnew = 2'd1;
        #1 chk("both_match_m", hz.stall, 1);

        // Register zero and not-read sources
        idle_in();
        hz.E_wa = 5'd0; hz.D_rs = 5'd0; hz.E_tnew = 2'd2; hz.D_tuse_rs = 2'd0;
        #1 chk("reg_zero", hz.stall, 0);
        idle_in();
        hz.D_rt = 5'd7; hz.E_wa = 5'd7; hz.E_tnew = 2'd2; hz.D_tuse_rt = 2'd3;
        #1 chk("tuse_none", hz.stall, 0);
        idle_in();

        // MULT then MFLO: six stall cycles, proceeds on the seventh
        reset = 1'b1; #1 reset = 1'b0;
        tick();
        hz.E_md_start = 1'b1; hz.E_md_div = 1'b0; hz.D_md_use = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("mult_stall_%0d", i), hz.stall, 1);
            chk($sformatf("mult_busy_%0d", i), hz.md_busy, 1);
            tick();
            hz.E_md_start = 1'b0;
        end
        #1;
        chk("mult_done_stall", hz.stall, 0);
        chk("mult_done_busy", hz.md_busy, 0);
        chk("mult_stall_cnt", hz.stall_cnt, CNT_EN ? 32'd6 : 32'd0);
        hz.D_md_use = 1'b0;

`ifdef HZ_STALL_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        #1 chk("preload", hz.stall_cnt, 32'hFFFF_FFFF);
        hz.E_wa = 5'd8; hz.E_tnew = 2'd2; hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd0;
        tick();
        chk("wrap", hz.stall_cnt, 32'd0);
        idle_in();
        tick();
`endif

        // DIV followed by independent work: no stall, busy 11 cycles
        hz.E_md_start = 1'b1; hz.E_md_div = 1'b1; hz.D_md_use = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk($sformatf("div_nostall_%0d", i), hz.stall, 0);
            chk($sformatf("div_busy_%0d", i), hz.md_busy, 1);
            tick();
            hz.E_md_start = 1'b0;
        end
        #1 chk("div_done_busy", hz.md_busy, 0);
        tick();

        // Asynchronous reset mid-DIV at cnt=4
        hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
        tick();
        hz.E_md_start = 1'b0; hz.D_md_use = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("div_cnt4_busy", hz.md_busy, 1);
        chk("div_cnt4_stall_cnt", hz.stall_cnt, CNT_EN ? 32'd6 : 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", hz.md_busy, 0);
        chk("async_rst_stall", hz.stall, 0);
        chk("async_rst_cnt", hz.stall_cnt, 0);
        #1 reset = 1'b0;
        #1 chk("post_rst_hilo", hz.stall, 0);
        tick();
        chk("post_rst_hilo_next", hz.stall, 0);
        chk("post_rst_stall_cnt", hz.stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
